ddr_wr_sched: RTL and testbench

Two-channel write scheduler in front of the `ddr_axi_write` AXI4 write master. It watches two producer FIFOs and, with round-robin arbitration, issues fixed-length bursts to the write master. Each channel has its own circular DDR address window; per-channel write pointers advance and wrap inside that window. The scheduler also steers the master's FIFO data and read strobe to the granted channel.

---
 rtl/ddr_pkg.sv | 18 +
 rtl/ddr_wr_ptr.sv | 34 +++
 rtl/ddr_wr_sched.sv | 111 +++++++++++
 tb/tb_ddr_wr_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR write path: scheduler state encoding and AXI burst constants.
package ddr_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_BURST  = 2'd2,
    S_UPDATE = 2'd3
  } sched_state_t;

  localparam logic [2:0] AXI_AWSIZE     = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic int bpb(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ddr_wr_ptr.sv
// Per-channel circular write pointer: reloads base while disabled, advances one burst and wraps.
module ddr_wr_ptr #(
  parameter int ADDR_WIDTH = 29,
  parameter int STEP       = 128
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] size,
  input  logic                  adv,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  wrap
);

  logic [ADDR_WIDTH:0] nxt;
  logic [ADDR_WIDTH:0] lim;

  // One extra bit so a window ending at the top of the address space still compares correctly.
  assign nxt  = {1'b0, ptr} + (ADDR_WIDTH+1)'(STEP);
  assign lim  = {1'b0, base} + {1'b0, size};
  assign wrap = en && adv && (nxt >= lim);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ptr <= '0;
    end else if (!en) begin
      ptr <= base;
    end else if (adv) begin
      ptr <= wrap ? base : nxt[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ddr_wr_sched.sv
// Two-channel round-robin burst scheduler feeding the AXI write master.
// state    | meaning
// S_IDLE   | wait for master ready and an eligible channel; latch grant and start address
// S_START  | one-cycle wr_start to the master
// S_BURST  | steer data and pops to the granted channel until wr_done
// S_UPDATE | advance/wrap the granted pointer, record last grant
module ddr_wr_sched
  import ddr_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 29,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int BURST_LEN       = 16,
  parameter int LVL_WIDTH       = 10
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       ch0_en,
  input  logic [ADDR_WIDTH-1:0]      ch0_base,
  input  logic [ADDR_WIDTH-1:0]      ch0_size,
  input  logic [LVL_WIDTH-1:0]       ch0_level,
  input  logic [DATA_WIDTH-1:0]      ch0_data,
  output logic                       ch0_rd_en,
  output logic                       ch0_wrap,
  input  logic                       ch1_en,
  input  logic [ADDR_WIDTH-1:0]      ch1_base,
  input  logic [ADDR_WIDTH-1:0]      ch1_size,
  input  logic [LVL_WIDTH-1:0]       ch1_level,
  input  logic [DATA_WIDTH-1:0]      ch1_data,
  output logic                       ch1_rd_en,
  output logic                       ch1_wrap,
  output logic                       wr_start,
  output logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
  output logic [ADDR_WIDTH-1:0]      wr_start_addr,
  input  logic                       wr_ready,
  output logic [DATA_WIDTH-1:0]      wr_fifo_rd_data,
  input  logic                       wr_fifo_rd_valid,
  input  logic                       wr_done,
  output logic                       busy
);

  localparam int STEP = BURST_LEN * bpb(DATA_WIDTH);

  sched_state_t          state, state_nxt;
  logic                  grant, grant_nxt;
  logic                  last;
  logic [1:0]            elig;
  logic [ADDR_WIDTH-1:0] ptr0, ptr1;
  logic                  adv0, adv1;
  logic                  in_burst;

  assign elig[0] = ch0_en && (ch0_level >= LVL_WIDTH'(BURST_LEN));
  assign elig[1] = ch1_en && (ch1_level >= LVL_WIDTH'(BURST_LEN));

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      S_IDLE: begin
        if (wr_ready && (elig != 2'b00)) begin
          grant_nxt = (elig == 2'b11) ? ~last : elig[1];
          state_nxt = S_START;
        end
      end
      S_START:  state_nxt = S_BURST;
      S_BURST:  if (wr_done) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      grant         <= 1'b0;
      last          <= 1'b1;
      wr_start_addr <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == S_IDLE && state_nxt == S_START)
        wr_start_addr <= grant_nxt ? ptr1 : ptr0;
      if (state == S_UPDATE)
        last <= grant;
    end
  end

  assign busy         = (state != S_IDLE);
  assign wr_start     = (state == S_START);
  assign wr_burst_len = BURST_LEN_WIDTH'(BURST_LEN);
  assign in_burst     = (state == S_BURST);

  // Pops only count inside the burst window; stray master strobes elsewhere are dropped.
  assign ch0_rd_en       = wr_fifo_rd_valid && in_burst && !grant;
  assign ch1_rd_en       = wr_fifo_rd_valid && in_burst &&  grant;
  assign wr_fifo_rd_data = grant ? ch1_data : ch0_data;

  assign adv0 = (state == S_UPDATE) && !grant;
  assign adv1 = (state == S_UPDATE) &&  grant;

  ddr_wr_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .STEP(STEP)) u_ptr0 (
    .ACLK(ACLK), .ARESETN(ARESETN), .en(ch0_en), .base(ch0_base), .size(ch0_size),
    .adv(adv0), .ptr(ptr0), .wrap(ch0_wrap)
  );

  ddr_wr_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .STEP(STEP)) u_ptr1 (
    .ACLK(ACLK), .ARESETN(ARESETN), .en(ch1_en), .base(ch1_base), .size(ch1_size),
    .adv(adv1), .ptr(ptr1), .wrap(ch1_wrap)
  );

endmodule

// File: tb/tb_ddr_wr_sched.sv
// Scoreboard bench for ddr_wr_sched: a behavioural write master serves each expected burst.
module tb_ddr_wr_sched;

  localparam logic [63:0] D0 = 64'hA0A0_0000_1111_2222;
  localparam logic [63:0] D1 = 64'hB1B1_0000_3333_4444;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        ch0_en, ch1_en;
  logic [28:0] ch0_base, ch0_size, ch1_base, ch1_size;
  logic [9:0]  ch0_level, ch1_level;
  logic [63:0] ch0_data, ch1_data;
  logic        ch0_rd_en, ch0_wrap, ch1_rd_en, ch1_wrap;
  logic        wr_start;
  logic [7:0]  wr_burst_len;
  logic [28:0] wr_start_addr;
  logic        wr_ready;
  logic [63:0] wr_fifo_rd_data;
  logic        wr_fifo_rd_valid, wr_done, busy;

  typedef struct {
    bit          ch;
    logic [28:0] addr;
    bit          wrap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   dis_beat = -1;

  always #5 ACLK = ~ACLK;

  ddr_wr_sched dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ch0_en(ch0_en), .ch0_base(ch0_base), .ch0_size(ch0_size), .ch0_level(ch0_level),
    .ch0_data(ch0_data), .ch0_rd_en(ch0_rd_en), .ch0_wrap(ch0_wrap),
    .ch1_en(ch1_en), .ch1_base(ch1_base), .ch1_size(ch1_size), .ch1_level(ch1_level),
    .ch1_data(ch1_data), .ch1_rd_en(ch1_rd_en), .ch1_wrap(ch1_wrap),
    .wr_start(wr_start), .wr_burst_len(wr_burst_len), .wr_start_addr(wr_start_addr),
    .wr_ready(wr_ready), .wr_fifo_rd_data(wr_fifo_rd_data),
    .wr_fifo_rd_valid(wr_fifo_rd_valid), .wr_done(wr_done), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input bit ch, input logic [28:0] addr, input bit wrap);
    exp_t e;
    e.ch = ch; e.addr = addr; e.wrap = wrap;
    sb.push_back(e);
  endtask

  task automatic idle_all();
    ch0_en = 1'b0;
    ch1_en = 1'b0;
    repeat (2) tick();
  endtask

  // Plays the write master for nb bursts, comparing each against the scoreboard head.
  task automatic serve(input int nb);
    for (int b = 0; b < nb; b++) begin
      exp_t e;
      int   t  = 0;
      int   p0 = 0;
      int   p1 = 0;
      while (!wr_start && t < 100) begin
        tick();
        t++;
      end
      if (!wr_start) begin
        check("start_timeout", 0, 1);
        return;
      end
      if (sb.size() == 0) begin
        check("sb_underflow", 0, 1);
        return;
      end
      e = sb.pop_front();
      check("addr", wr_start_addr, e.addr);
      check("len", wr_burst_len, 16);
      tick();
      check("start_one_cycle", wr_start, 0);
      wr_fifo_rd_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
        #1;
        p0 += int'(ch0_rd_en);
        p1 += int'(ch1_rd_en);
        check("data", wr_fifo_rd_data, e.ch ? D1 : D0);
        if (i == dis_beat) begin
          ch0_en   = 1'b0;
          ch0_base = 29'h2000;
        end
        tick();
      end
      wr_fifo_rd_valid = 1'b0;
      check("pops_own", e.ch ? p1 : p0, 16);
      check("pops_other", e.ch ? p0 : p1, 0);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      check("busy_update", busy, 1);
      check("wrap0", ch0_wrap, e.wrap && !e.ch);
      check("wrap1", ch1_wrap, e.wrap && e.ch);
      tick();
      check("busy_idle", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    ARESETN = 1'b0;
    ch0_en = 0; ch1_en = 0;
    ch0_base = 29'h1000; ch0_size = 29'h400; ch0_level = 10'd16; ch0_data = D0;
    ch1_base = 29'h8000; ch1_size = 29'h400; ch1_level = 10'd16; ch1_data = D1;
    wr_ready = 1'b1; wr_fifo_rd_valid = 1'b0; wr_done = 1'b0;
    repeat (3) tick();
    check("rst_start", wr_start, 0);
    check("rst_addr", wr_start_addr, 0);
    check("rst_len", wr_burst_len, 16);
    check("rst_rd_en", {ch1_rd_en, ch0_rd_en}, 0);
    check("rst_wrap", {ch1_wrap, ch0_wrap}, 0);
    check("rst_busy", busy, 0);
    ARESETN = 1'b1;
    tick();

    // Stray master strobes with both channels disabled.
    wr_fifo_rd_valid = 1'b1;
    wr_done = 1'b1;
    seen = 0;
    repeat (5) begin
      tick();
      seen |= busy | wr_start | ch0_rd_en | ch1_rd_en;
    end
    wr_fifo_rd_valid = 1'b0;
    wr_done = 1'b0;
    check("glitch_guard", seen, 0);

    // Round-robin with both eligible; last resets to 1 so ch0 wins first.
    push(0, 29'h1000, 0); push(1, 29'h8000, 0);
    push(0, 29'h1080, 0); push(1, 29'h8080, 0);
    ch0_en = 1; ch1_en = 1;
    serve(4);
    idle_all();

    // Single channel.
    push(0, 29'h1000, 0); push(0, 29'h1080, 0);
    ch0_en = 1;
    serve(2);
    idle_all();

    // Wrap with a two-burst window.
    ch0_size = 29'h100;
    tick();
    push(0, 29'h1000, 0); push(0, 29'h1080, 1); push(0, 29'h1000, 0);
    ch0_en = 1;
    serve(3);
    idle_all();

    // Threshold.
    ch0_size = 29'h400;
    ch0_level = 10'd15;
    ch0_en = 1;
    seen = 0;
    repeat (10) begin
      tick();
      seen |= wr_start | busy;
    end
    check("thr_below", seen, 0);
    ch0_level = 10'd16;
    n = 0;
    while (!wr_start && n < 20) begin
      tick();
      n++;
    end
    check("thr_latency", n, 1);
    push(0, 29'h1000, 0);
    serve(1);
    idle_all();

    // Disable mid-burst and rebase.
    push(0, 29'h1000, 0);
    dis_beat = 5;
    ch0_en = 1;
    serve(1);
    dis_beat = -1;
    check("dis_base_applied", ch0_base, 29'h2000);
    push(0, 29'h2000, 0);
    ch0_en = 1;
    serve(1);
    idle_all();

    // Asynchronous reset in the middle of a burst.
    ch0_base = 29'h3000;
    tick();
    ch0_en = 1;
    n = 0;
    while (!wr_start && n < 20) begin
      tick();
      n++;
    end
    check("rst_mid_start", wr_start, 1);
    check("rst_mid_addr", wr_start_addr, 29'h3000);
    tick();
    wr_fifo_rd_valid = 1'b1;
    repeat (3) tick();
    check("rst_mid_pre_rd", ch0_rd_en, 1);
    #2 ARESETN = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_start0", wr_start, 0);
    check("rst_mid_rd_en", {ch1_rd_en, ch0_rd_en}, 0);
    check("rst_mid_addr0", wr_start_addr, 0);
    wr_fifo_rd_valid = 1'b0;
    ch0_en = 1'b0;
    repeat (2) tick();
    ARESETN = 1'b1;
    repeat (2) tick();
    push(0, 29'h3000, 0);
    ch0_en = 1;
    serve(1);
    idle_all();

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
